// File: rtl/div_pkg.sv
// Shared types and helpers for the pipelined restoring divider (div_pipe_param).
package div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_TAG_W = 4;
    localparam int DIV_MAX_W = 64;

    // Stage payload at the default widths; modules rebuild it at their own widths.
    typedef struct packed {
        logic                 valid;
        logic [DIV_WIDTH-1:0] rem;
        logic [DIV_WIDTH-1:0] quo;
        logic [DIV_WIDTH-1:0] divisor;
        logic                 neg_q;
        logic                 neg_r;
        logic                 dz;
        logic                 ovf;
        logic [DIV_TAG_W-1:0] tag;
    } div_stage_t;

    function automatic logic [DIV_MAX_W-1:0] twos_neg(input logic [DIV_MAX_W-1:0] x);
        return ~x + 64'd1;
    endfunction

    function automatic logic [DIV_MAX_W-1:0] abs_if(input logic [DIV_MAX_W-1:0] x,
                                                    input logic neg);
        return neg ? twos_neg(x) : x;
    endfunction

    // Most negative two's-complement value of a w-bit word.
    function automatic logic [DIV_MAX_W-1:0] signed_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/div_pipe_stage.sv
// One restoring shift/subtract step of the divider, registered, with advance enable.
module div_pipe_stage
    import div_pkg::*;
#(
    parameter int  WIDTH   = DIV_WIDTH,
    parameter type stage_t = div_stage_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   adv,
    input  stage_t d,
    output stage_t q
);

    stage_t           nxt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        nxt     = d;
        shifted = {d.rem, d.quo[WIDTH-1]};
        trial   = shifted - {1'b0, d.divisor};
        // Special cases carry their operands through untouched for the output fix-up.
        if (!(d.dz || d.ovf)) begin
            nxt.quo = {d.quo[WIDTH-2:0], ~trial[WIDTH]};
            nxt.rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (adv) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/div_pipe_param.sv
// Pipelined signed/unsigned restoring divider, WIDTH+1 stages, valid/ready on both sides.
// Define DIV_BUBBLE_COLLAPSE_EN for per-stage advance (bubbles compress behind a stall).
module div_pipe_param
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int TAG_W = DIV_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dz,
    output logic             out_ovf
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] quo;
        logic [WIDTH-1:0] divisor;
        logic             neg_q;
        logic             neg_r;
        logic             dz;
        logic             ovf;
        logic [TAG_W-1:0] tag;
    } stage_t;

    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(signed_min(WIDTH));

    // Handshake: a transfer happens on any edge where valid && ready; ld[i] lets stage i load.
    logic [WIDTH:0] ld;
    stage_t         pre;
    stage_t         stg_p;
    stage_t         stg [0:WIDTH];
    stage_t         last;
    logic           sgn_a;
    logic           sgn_b;

    always_comb begin
        sgn_a       = in_signed & in_dividend[WIDTH-1];
        sgn_b       = in_signed & in_divisor[WIDTH-1];
        pre         = '0;
        pre.valid   = in_valid;
        pre.tag     = in_tag;
        pre.dz      = (in_divisor == '0);
        pre.ovf     = in_signed && (in_dividend == MIN_VAL) && (in_divisor == '1);
        if (pre.dz) begin
            // Raw dividend rides in quo so the remainder can echo it unchanged.
            pre.quo = in_dividend;
        end else if (!pre.ovf) begin
            pre.quo     = WIDTH'(abs_if(64'(in_dividend), sgn_a));
            pre.divisor = WIDTH'(abs_if(64'(in_divisor), sgn_b));
            pre.neg_q   = sgn_a ^ sgn_b;
            pre.neg_r   = sgn_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_p <= '0;
        end else if (ld[0]) begin
            stg_p <= pre;
        end
    end

    assign stg[0] = stg_p;

    for (genvar i = 1; i <= WIDTH; i++) begin : g_step
        div_pipe_stage #(
            .WIDTH   (WIDTH),
            .stage_t (stage_t)
        ) u_step (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (ld[i]),
            .d     (stg[i-1]),
            .q     (stg[i])
        );
    end

    assign last = stg[WIDTH];

`ifdef DIV_BUBBLE_COLLAPSE_EN
    // A stage may load when it is empty or its contents move on this edge.
    always_comb begin
        ld[WIDTH] = !last.valid || out_ready;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            ld[i] = !stg[i].valid || ld[i+1];
        end
    end
`else
    assign ld = {(WIDTH+1){!last.valid || out_ready}};
`endif

    assign in_ready = ld[0];

    always_comb begin
        out_valid     = last.valid;
        out_quotient  = '0;
        out_remainder = '0;
        out_tag       = '0;
        out_dz        = 1'b0;
        out_ovf       = 1'b0;
        if (last.valid) begin
            out_tag = last.tag;
            out_dz  = last.dz;
            out_ovf = last.ovf;
            if (last.dz) begin
                out_quotient  = '1;
                out_remainder = last.quo;
            end else if (last.ovf) begin
                out_quotient  = MIN_VAL;
                out_remainder = '0;
            end else begin
                out_quotient  = last.neg_q ? WIDTH'(twos_neg(64'(last.quo))) : last.quo;
                out_remainder = last.neg_r ? WIDTH'(twos_neg(64'(last.rem))) : last.rem;
            end
        end
    end

endmodule

// File: tb/tb_div_pipe_param.sv
// Scoreboard bench for div_pipe_param at WIDTH=16, TAG_W=4.
module tb_div_pipe_param;

    localparam int W  = 16;
    localparam int TW = 4;
    localparam int EW = 2 * W + TW + 2;
    localparam int L  = W + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_signed;
    logic [W-1:0]  in_dividend;
    logic [W-1:0]  in_divisor;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_quotient;
    logic [W-1:0]  out_remainder;
    logic [TW-1:0] out_tag;
    logic          out_dz;
    logic          out_ovf;

    logic [EW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            rdy_mode = 0;
    int            acc_cnt = 0;
    int            del_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [EW:0]   held;

    div_pipe_param #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_signed     (in_signed),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_tag       (out_tag),
        .out_dz        (out_dz),
        .out_ovf       (out_ovf)
    );

    // Clock and reset-independent cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] pk(input logic [W-1:0] q, input logic [W-1:0] r,
                                         input logic [TW-1:0] t, input logic dz, input logic ovf);
        return {q, r, t, dz, ovf};
    endfunction

    // Reference model built on the simulator's own truncating division.
    function automatic logic [EW-1:0] model(input logic sg, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [TW-1:0] t);
        int sa;
        int sb;
        if (b == '0) return pk('1, a, t, 1'b1, 1'b0);
        if (sg && a == 16'h8000 && b == 16'hFFFF) return pk(16'h8000, '0, t, 1'b0, 1'b1);
        if (sg) begin
            sa = $signed(a);
            sb = $signed(b);
            return pk(W'(sa / sb), W'(sa % sb), t, 1'b0, 1'b0);
        end
        return pk(a / b, a % b, t, 1'b0, 1'b0);
    endfunction

    // Driver tasks
    task automatic issue(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] t, input logic [EW-1:0] e, output int acc_cyc);
        logic acc;
        int   waited;
        acc    = 1'b0;
        waited = 0;
        acc_cyc = -1;
        in_valid    = 1'b1;
        in_signed   = sg;
        in_dividend = a;
        in_divisor  = b;
        in_tag      = t;
        exp_q.push_back(e);
        while (!acc && waited < 300) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) acc_cyc = cyc;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!acc) check("accept_timeout", 64'(waited), 64'(0));
        in_valid = 1'b0;
    endtask

    task automatic check_latency(input int acc_cyc);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(cyc - acc_cyc), 64'(L));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_quotient"}, 64'(out_quotient), 64'(0));
        check({tag, "_remainder"}, 64'(out_remainder), 64'(0));
        check({tag, "_flags_tag"}, 64'({out_tag, out_dz, out_ovf}), 64'(0));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int            inflight;
        if (!rst_n) begin
            acc_cnt    = 0;
            del_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            inflight = acc_cnt - del_cnt;
`ifdef DIV_BUBBLE_COLLAPSE_EN
            check("in_ready", 64'(in_ready), 64'((inflight < L) || out_ready));
`else
            check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
`endif
            if (prev_stall)
                check("hold", 64'({out_valid, out_quotient, out_remainder, out_tag, out_dz, out_ovf}),
                      64'(held));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(out_tag), 64'(-1));
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'({out_quotient, out_remainder, out_tag, out_dz, out_ovf}), 64'(e));
                end
                del_cnt++;
            end
            if (in_valid && in_ready) acc_cnt++;
            prev_stall = out_valid && !out_ready;
            held = {out_valid, out_quotient, out_remainder, out_tag, out_dz, out_ovf};
        end
    end

    initial begin
        int            acc_cyc;
        logic          sg;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_signed   = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        in_tag      = '0;
        out_ready   = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors, expected values worked out by hand
        issue(1'b0, 16'd100, 16'd7, 4'h5, pk(16'd14, 16'd2, 4'h5, 1'b0, 1'b0), acc_cyc);
        check_latency(acc_cyc);
        drain();
        issue(1'b1, 16'hFFF9, 16'h0002, 4'h1, pk(16'hFFFD, 16'hFFFF, 4'h1, 1'b0, 1'b0), acc_cyc);
        issue(1'b1, 16'h0007, 16'hFFFE, 4'h2, pk(16'hFFFD, 16'h0001, 4'h2, 1'b0, 1'b0), acc_cyc);
        issue(1'b0, 16'd1234, 16'h0000, 4'h3, pk(16'hFFFF, 16'd1234, 4'h3, 1'b1, 1'b0), acc_cyc);
        issue(1'b1, 16'd1234, 16'h0000, 4'h4, pk(16'hFFFF, 16'd1234, 4'h4, 1'b1, 1'b0), acc_cyc);
        issue(1'b1, 16'hFB2E, 16'h0000, 4'h6, pk(16'hFFFF, 16'hFB2E, 4'h6, 1'b1, 1'b0), acc_cyc);
        issue(1'b1, 16'h8000, 16'hFFFF, 4'h7, pk(16'h8000, 16'h0000, 4'h7, 1'b0, 1'b1), acc_cyc);
        issue(1'b0, 16'h8000, 16'hFFFF, 4'h8, pk(16'h0000, 16'h8000, 4'h8, 1'b0, 1'b0), acc_cyc);
        issue(1'b1, 16'hFF9C, 16'h0007, 4'h9, pk(16'hFFF2, 16'hFFFE, 4'h9, 1'b0, 1'b0), acc_cyc);
        issue(1'b0, 16'hFFFF, 16'h0001, 4'hA, pk(16'hFFFF, 16'h0000, 4'hA, 1'b0, 1'b0), acc_cyc);
        issue(1'b1, 16'h8000, 16'h0001, 4'hB, pk(16'h8000, 16'h0000, 4'hB, 1'b0, 1'b0), acc_cyc);
        drain();

        // Back-to-back stream under random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 20; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = W'($urandom_range(0, 16'hFFFF));
            b  = (i % 2 == 0) ? W'($urandom_range(1, 40)) : W'($urandom_range(0, 16'hFFFF));
            if (i % 7 == 3) b = '0;
            if (i == 11) begin
                sg = 1'b1;
                a  = 16'h8000;
                b  = 16'hFFFF;
            end
            issue(sg, a, b, TW'(i), model(sg, a, b, TW'(i)), acc_cyc);
        end
        drain();

        // Reset with operations in flight and the output stalled
        rdy_mode = 2;
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, W'(1000 + i), 16'd3, TW'(i), model(1'b0, W'(1000 + i), 16'd3, TW'(i)), acc_cyc);
        end
        for (int n = 0; n < 100 && !out_valid; n++) begin
            @(posedge clk);
            #1;
        end
        check("stalled_out_valid", 64'(out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        rdy_mode = 0;
        issue(1'b0, 16'd500, 16'd9, 4'hC, pk(16'd55, 16'd5, 4'hC, 1'b0, 1'b0), acc_cyc);
        check_latency(acc_cyc);
        drain();
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_pipe_param.md
Name: div_pipe_param

Overview:
- Parametrised successor to the fixed 16-bit restoring-division pipeline.
- Configurable operand width; valid/ready handshake with backpressure; per-operation signed/unsigned mode.
- Defined divide-by-zero and signed-overflow results; opaque tag carried alongside each operation.
- Sits in the ALU as the long-latency DIV/MOD unit. The execute stage issues into it, and writeback drains it.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 4).
- TAG_W, 4, width of the opaque tag (e.g. destination register index) carried with each operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  unit accepts the operation this cycle
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned
- in_dividend  input  WIDTH  dividend
- in_divisor  input  WIDTH  divisor
- in_tag  input  TAG_W  opaque tag
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result this cycle
- out_quotient  output  WIDTH  quotient
- out_remainder  output  WIDTH  remainder
- out_tag  output  TAG_W  tag of this result
- out_dz  output  1  divisor was zero
- out_ovf  output  1  signed overflow (MIN / -1)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: all stage valid bits 0. out_valid=0, out_quotient=0, out_remainder=0, out_tag=0, out_dz=0, out_ovf=0.
- Reset mid-operation: all in-flight operations are discarded, with no output produced.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - out_* are held stable while out_valid && !out_ready.
- Pipeline structure: L = WIDTH+1 register stages.
  - Stage P (pre-stage) registers abs(dividend), abs(divisor), sign flags, dz, ovf and tag.
    - In unsigned mode, abs is the identity.
  - Stages 1..WIDTH each perform one restoring shift/subtract step on a {rem[WIDTH-1:0], quo[WIDTH-1:0]} accumulator, producing one quotient bit MSB-first.
  - Trial subtraction is WIDTH+1 bits wide.
- Output sign fix-up: combinational from the last stage register.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign (truncating division).
- Latency: L cycles from accept to out_valid with no stall. Throughput is 1 operation per cycle.
- Stall (default): global enable = !(out_valid && !out_ready).
  - in_ready = enable, so the whole pipeline freezes as one.
  - Bubbles are not collapsed.
- Divide by zero: out_quotient = all ones, out_remainder = original dividend, out_dz=1. This holds in both modes.
- Signed overflow (dividend = MIN, divisor = -1, in_signed=1): out_quotient = MIN, out_remainder = 0, out_ovf=1.
- out_dz and out_ovf are never both 1.
- Order: results leave in acceptance order, always.
- Simultaneous accept and drain while full: both happen on the same edge, with no loss.

Optional Feature:
- Macro: DIV_BUBBLE_COLLAPSE_EN.
- Defined: each stage advances when its successor is empty or advancing.
  - in_ready = stage P empty or advancing.
  - Bubbles compress behind a stalled output, so up to L operations are held while stalled.
- Undefined: the global-enable stall described above.
- Ordering and results are identical in both builds; only the in_ready timing differs.

Decomposition:
- Package div_pkg:
  - stage payload struct: valid, rem, quo, divisor, neg_q, neg_r, dz, ovf, tag, parameterised via WIDTH/TAG_W localparams;
  - function for two's-complement abs/negate;
  - constant for signed MIN.
- Sub-module div_pipe_stage (WIDTH, TAG_W): one registered shift/subtract step with advance enable. Instantiated WIDTH times in a generate loop.

Test Plan:
- Unsigned, WIDTH=16, 100/7 -> q=14, r=2, out_valid exactly 17 cycles after accept, tag echoed.
- Signed, -7 (0xFFF9) / 2 -> q=0xFFFD (-3), r=0xFFFF (-1). Then 7 / -2 -> q=0xFFFD, r=1.
- 1234/0, unsigned and signed -> q=0xFFFF, r=1234, out_dz=1, out_ovf=0.
- Signed 0x8000 / 0xFFFF -> q=0x8000, r=0, out_ovf=1. The same operands unsigned -> q=0, r=0x8000, flags 0.
- 20 back-to-back random operations with out_ready toggled randomly -> all results in order, none lost or duplicated, out_* stable while stalled. Repeat with DIV_BUBBLE_COLLAPSE_EN defined and check that in_ready stays high while bubbles exist.
- Assert rst_n low with 5 operations in flight -> outputs return to reset values immediately. After release, no stale results appear and the next operation completes in 17 cycles.
